// File: rtl/lights_out_input.sv
`default_nettype none
// ============================================================================
//  Module      : lights_out_input
//  Description : Button front end for a Lights Out game. Synchronizes and
//                debounces five raw buttons, turns debounced rising edges into
//                cursor moves, and issues valid/ready toggle requests for the
//                cell under the cursor.
//  Ports       : clk        - rising-edge clock
//                rst        - synchronous active-high reset
//                ena        - when low, debounced events are discarded
//                btn_raw    - raw buttons {press,right,left,down,up}
//                cursor_x/y - current cursor column / row
//                move_valid - toggle request pending
//                move_idx   - pending cell index, y*BOARD_W+x
//                move_ready - game core accepts the pending request
//                move_drop  - one-cycle pulse when a press is discarded
//  Config      : define LIGHTS_OUT_WRAP_EN to make the cursor wrap at the
//                board edges instead of saturating.
//  Revision    : 1.0 - initial release
// ============================================================================
module lights_out_input #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BOARD_W         = 5,
  parameter int BOARD_H         = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [4:0] btn_raw,
  output logic [2:0] cursor_x,
  output logic [2:0] cursor_y,
  output logic       move_valid,
  output logic [5:0] move_idx,
  input  logic       move_ready,
  output logic       move_drop
);

  localparam logic [7:0] c_CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] c_XMAX    = 3'(BOARD_W - 1);
  localparam logic [2:0] c_YMAX    = 3'(BOARD_H - 1);
`ifdef LIGHTS_OUT_WRAP_EN
  localparam bit c_WRAP = 1'b1;
`else
  localparam bit c_WRAP = 1'b0;
`endif

  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic [4:0] r_level;
  logic [4:0] r_rise;
  logic [7:0] r_cnt [5];

  logic [2:0] r_x;
  logic [2:0] r_y;
  logic       r_valid;
  logic [5:0] r_idx;
  logic       r_drop;

  logic [4:0] w_evt;
  logic [2:0] w_xn;
  logic [2:0] w_yn;
  logic [5:0] w_cur_idx;
  logic       w_accept;

  // Two-flop synchronizer on every raw button.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: the counter measures how long the synchronized value has
  // disagreed with the accepted level; any agreement restarts it. r_rise
  // flags the cycle right after the level goes 0->1 (releases are ignored).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
      r_rise  <= '0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        r_rise[i] <= 1'b0;
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == c_CNT_MAX) begin
          r_level[i] <= r_sync2[i];
          r_rise[i]  <= r_sync2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign w_evt     = r_rise & {5{ena}};
  assign w_accept  = r_valid & move_ready;
  // Index uses the cursor before this cycle's move is applied.
  assign w_cur_idx = 6'(r_y) * 6'(BOARD_W) + 6'(r_x);

  // Next cursor position; opposite directions on one axis cancel.
  always_comb begin
    w_xn = r_x;
    w_yn = r_y;
    if (w_evt[3] && !w_evt[2])
      w_xn = (r_x == c_XMAX) ? (c_WRAP ? 3'd0 : r_x) : r_x + 3'd1;
    if (w_evt[2] && !w_evt[3])
      w_xn = (r_x == 3'd0) ? (c_WRAP ? c_XMAX : r_x) : r_x - 3'd1;
    if (w_evt[1] && !w_evt[0])
      w_yn = (r_y == c_YMAX) ? (c_WRAP ? 3'd0 : r_y) : r_y + 3'd1;
    if (w_evt[0] && !w_evt[1])
      w_yn = (r_y == 3'd0) ? (c_WRAP ? c_YMAX : r_y) : r_y - 3'd1;
  end

  // Cursor and request handshake. A press arriving in the accept cycle
  // replaces the outgoing request, so the slot is free for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_x    <= w_xn;
      r_y    <= w_yn;
      r_drop <= 1'b0;
      if (w_evt[4]) begin
        if (!r_valid || w_accept) begin
          r_valid <= 1'b1;
          r_idx   <= w_cur_idx;
        end else begin
          r_drop <= 1'b1;
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign cursor_x   = r_x;
  assign cursor_y   = r_y;
  assign move_valid = r_valid;
  assign move_idx   = r_idx;
  assign move_drop  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_lights_out_input.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lights_out_input
//  Description : Self-checking bench for lights_out_input. A behavioural model
//                keeps the raw button history since reset and accepts a new
//                button level once the last DEBOUNCE_CYCLES synchronized
//                samples all disagree with the current level.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lights_out_input;

  localparam int D = 16;
  localparam int W = 5;
  localparam int H = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [4:0] btn_raw = '0;
  logic [2:0] cursor_x;
  logic [2:0] cursor_y;
  logic       move_valid;
  logic [5:0] move_idx;
  logic       move_ready = 1'b0;
  logic       move_drop;

  lights_out_input #(.DEBOUNCE_CYCLES(D), .BOARD_W(W), .BOARD_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .btn_raw    (btn_raw),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .move_valid (move_valid),
    .move_idx   (move_idx),
    .move_ready (move_ready),
    .move_drop  (move_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [4:0] rq[$];
  bit   [4:0] m_lvl  = '0;
  bit   [4:0] m_rose = '0;
  int m_x = 0, m_y = 0, m_v = 0, m_idx = 0, m_drop = 0;

  function automatic int mv(input int v, input int d, input int n);
    int nv;
    nv = v + d;
`ifdef LIGHTS_OUT_WRAP_EN
    if (nv < 0)  nv = n - 1;
    if (nv >= n) nv = 0;
`else
    if (nv < 0)  nv = 0;
    if (nv >= n) nv = n - 1;
`endif
    return nv;
  endfunction

  // Raw value of bit b driven before edge j after reset (zero before it).
  function automatic bit raw_at(input int j, input int b);
    logic [4:0] v;
    if (j < 1) return 1'b0;
    v = rq[j-1];
    return v[b];
  endfunction

  task automatic model_edge(input logic [4:0] b, input logic e, input logic rdy, input logic r);
    bit [4:0] evt;
    int       acc, k;
    bit       all_diff;
    if (r) begin
      rq.delete();
      m_lvl = '0; m_rose = '0;
      m_x = 0; m_y = 0; m_v = 0; m_idx = 0; m_drop = 0;
    end else begin
      rq.push_back(b);
      evt    = m_rose & {5{e}};
      acc    = m_v & int'(rdy);
      m_drop = 0;
      if (evt[4]) begin
        if (m_v == 0 || acc != 0) begin
          m_v = 1; m_idx = m_y * W + m_x;
        end else begin
          m_drop = 1;
        end
      end else if (acc != 0) begin
        m_v = 0;
      end
      if ((int'(evt[3]) - int'(evt[2])) != 0) m_x = mv(m_x, int'(evt[3]) - int'(evt[2]), W);
      if ((int'(evt[1]) - int'(evt[0])) != 0) m_y = mv(m_y, int'(evt[1]) - int'(evt[0]), H);
      // The debouncer at edge k sees the raw value from two edges earlier.
      k = rq.size();
      m_rose = '0;
      for (int i = 0; i < 5; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++)
          if (raw_at(k - 2 - j, i) == m_lvl[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_rose[i] = ~m_lvl[i];
          m_lvl[i]  = ~m_lvl[i];
        end
      end
    end
  endtask

  // One clock cycle: drive at negedge, model the edge, compare after it.
  task automatic step(input logic [4:0] b, input logic e, input logic rdy, input logic r);
    btn_raw = b; ena = e; move_ready = rdy; rst = r;
    model_edge(b, e, rdy, r);
    @(posedge clk);
    #1;
    check_eq("cursor_x", int'(cursor_x), m_x);
    check_eq("cursor_y", int'(cursor_y), m_y);
    check_eq("move_valid", int'(move_valid), m_v);
    if (m_v != 0) check_eq("move_idx", int'(move_idx), m_idx);
    check_eq("move_drop", int'(move_drop), m_drop);
    @(negedge clk);
  endtask

  task automatic tap(input logic [4:0] m, input logic rdy);
    repeat (20) step(m, 1'b1, rdy, 1'b0);
    repeat (20) step(5'b0, 1'b1, rdy, 1'b0);
  endtask

  initial begin
    int lat, nchg, ndrop, prev_x;
    logic [4:0] cur;
    logic       e, rdy, r;

    @(negedge clk);
    step(5'b0, 1'b0, 1'b0, 1'b1);
    step(5'b0, 1'b0, 1'b0, 1'b1);
    check_eq("reset_x", int'(cursor_x), 0);
    check_eq("reset_valid", int'(move_valid), 0);

    // Held right: exactly one move, roughly 2+D cycles after assertion.
    lat = -1; nchg = 0; prev_x = int'(cursor_x);
    for (int n = 1; n <= 40; n++) begin
      step(5'b01000, 1'b1, 1'b0, 1'b0);
      if (int'(cursor_x) != prev_x) begin
        nchg++;
        if (lat < 0) lat = n;
      end
      prev_x = int'(cursor_x);
    end
    check_eq("right_latency_ok", int'(lat >= 17 && lat <= 19), 1);
    check_eq("right_changes", nchg, 1);
    check_eq("right_x", int'(cursor_x), 1);
    repeat (20) step(5'b0, 1'b1, 1'b0, 1'b0);

    // Short press glitch: no event.
    repeat (10) step(5'b10000, 1'b1, 1'b0, 1'b0);
    repeat (30) step(5'b0, 1'b1, 1'b0, 1'b0);
    check_eq("glitch_valid", int'(move_valid), 0);

    // Walk to (4,2), press, press again (dropped), then accept.
    repeat (3) tap(5'b01000, 1'b0);
    repeat (2) tap(5'b00010, 1'b0);
    check_eq("pos_x", int'(cursor_x), 4);
    check_eq("pos_y", int'(cursor_y), 2);
    tap(5'b10000, 1'b0);
    check_eq("req_valid", int'(move_valid), 1);
    check_eq("req_idx", int'(move_idx), 14);
    ndrop = 0;
    repeat (20) begin step(5'b10000, 1'b1, 1'b0, 1'b0); ndrop += int'(move_drop); end
    repeat (20) begin step(5'b0, 1'b1, 1'b0, 1'b0);     ndrop += int'(move_drop); end
    check_eq("drop_pulses", ndrop, 1);
    check_eq("req_idx_held", int'(move_idx), 14);
    step(5'b0, 1'b1, 1'b1, 1'b0);
    check_eq("accepted_valid", int'(move_valid), 0);

    // Left at the origin.
    step(5'b0, 1'b1, 1'b0, 1'b1);
    tap(5'b00100, 1'b0);
`ifdef LIGHTS_OUT_WRAP_EN
    check_eq("left_edge_x", int'(cursor_x), 4);
`else
    check_eq("left_edge_x", int'(cursor_x), 0);
`endif

    // Up+down cancel while right applies.
    step(5'b0, 1'b1, 1'b0, 1'b1);
    tap(5'b00010, 1'b0);
    tap(5'b01011, 1'b0);
    check_eq("cancel_y", int'(cursor_y), 1);
    check_eq("cancel_x", int'(cursor_x), 1);

    // Pending request wiped by reset; press held through reset.
    tap(5'b10000, 1'b0);
    check_eq("pre_rst_valid", int'(move_valid), 1);
    step(5'b10000, 1'b1, 1'b0, 1'b1);
    check_eq("rst_valid", int'(move_valid), 0);
    check_eq("rst_x", int'(cursor_x), 0);
    check_eq("rst_y", int'(cursor_y), 0);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      step(5'b10000, 1'b1, 1'b0, 1'b0);
      if (lat < 0 && move_valid) lat = n;
    end
    check_eq("held_rst_latency_ok", int'(lat >= 17 && lat <= 19), 1);
    check_eq("held_rst_idx", int'(move_idx), 0);
    repeat (20) step(5'b0, 1'b1, 1'b1, 1'b0);

    // Randomized phase.
    cur = '0;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 24) == 0) cur[i] = ~cur[i];
      e   = ($urandom_range(0, 7) != 0);
      rdy = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 799) == 0);
      step(cur, e, rdy, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lights_out_input.md
LIGHTS_OUT_INPUT -- requirements
Module: lights_out_input

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable synchronized samples required to accept a button level change (range 2..255).
REQ-002 The block SHALL have parameter BOARD_W, default 5, meaning board columns (range 2..7).
REQ-003 The block SHALL have parameter BOARD_H, default 5, meaning board rows (range 2..7).
REQ-004 Port clk  input  1  is the single clock; all logic is on its rising edge.
REQ-005 Port rst  input  1  is the reset: synchronous, active-high.
REQ-006 Port ena  input  1  is the design-selected enable; when 0, the block accepts no new button events.
REQ-007 Port btn_raw  input  5  carries asynchronous raw buttons: bit0 up, bit1 down, bit2 left, bit3 right, bit4 press; active-high.
REQ-008 Port cursor_x  output  3  is the current cursor column.
REQ-009 Port cursor_y  output  3  is the current cursor row.
REQ-010 Port move_valid  output  1  means a toggle request is pending for the game core.
REQ-011 Port move_idx  output  6  is the cell index of the pending request, y*BOARD_W+x.
REQ-012 Port move_ready  input  1  means the game core accepts the request this cycle.
REQ-013 Port move_drop  output  1  is a one-cycle pulse when a press is discarded because a request is already pending.

Function
REQ-014 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Per button: while the synchronized value equals the debounced level, the counter SHALL be held at 0; otherwise it SHALL increment, and on reaching DEBOUNCE_CYCLES-1 the debounced level SHALL take the synchronized value and the counter SHALL clear.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the debounced level, and the counter SHALL restart from 0 after each glitch.
REQ-017 A button event SHALL be a 0->1 transition of the debounced level; a release SHALL generate nothing; holding a button SHALL NOT auto-repeat.
REQ-018 Events occurring while ena=0 SHALL be discarded; debouncing SHALL continue regardless of ena.
REQ-019 An up event SHALL decrement cursor_y, down increment cursor_y, left decrement cursor_x, right increment cursor_x, all in the cycle after the event.
REQ-020 Opposite-direction events in the same cycle (up+down, or left+right) SHALL cancel on that axis; events on different axes in the same cycle SHALL both apply.
REQ-021 On a press event with move_valid=0, the block SHALL set move_valid=1 and latch move_idx from the cursor value before any same-cycle move is applied.
REQ-022 move_valid and move_idx SHALL hold stable until a cycle with move_valid=1 and move_ready=1, after which move_valid SHALL be 0.
REQ-023 A press event in the same cycle as acceptance (move_valid=1, move_ready=1) SHALL load the new request, so move_valid stays 1; otherwise a press with move_valid=1 SHALL be dropped and SHALL pulse move_drop.
REQ-024 Cursor motion SHALL remain allowed while a request is pending and SHALL NOT alter the latched move_idx.
REQ-025 move_idx SHALL always be in 0..BOARD_W*BOARD_H-1.

Reset
REQ-026 While rst=1, synchronizers, debounced levels and counters SHALL clear to 0, cursor_x and cursor_y SHALL go to 0, move_valid, move_idx and move_drop SHALL go to 0.
REQ-027 Reset asserted mid-debounce or with a pending request SHALL discard all state; a button held through reset SHALL produce an event only after the full debounce period following rst deassertion.

Configuration
REQ-028 With macro LIGHTS_OUT_WRAP_EN defined, moves past an edge SHALL wrap around: x=BOARD_W-1 plus right goes to 0, and 0 plus left goes to BOARD_W-1; rows behave the same way.
REQ-029 Without LIGHTS_OUT_WRAP_EN, moves past an edge SHALL saturate and the cursor SHALL stay at the edge.

Verification
REQ-030 Hold btn_raw[3]=1 for 40 cycles from reset -> cursor_x goes 0->1 exactly once, 2+16 cycles after assertion (±1); no further change while the button is held.
REQ-031 Pulse btn_raw[4] for 10 cycles -> no event, move_valid stays 0; the debounce counter returns to 0.
REQ-032 Cursor (4,2), press with move_ready=0 -> move_valid=1, move_idx=14; a second press -> one-cycle move_drop pulse, move_idx still 14; move_ready=1 for one cycle -> move_valid=0.
REQ-033 Cursor (0,0), left event -> cursor_x=4 with LIGHTS_OUT_WRAP_EN defined, cursor_x=0 without it.
REQ-034 Up and down debounced in the same cycle with right -> cursor_y unchanged, cursor_x +1.
REQ-035 Pending request, then rst=1 for 1 cycle -> move_valid=0, cursor (0,0); press held through reset -> new request 18 cycles after release of rst, move_idx=0.
